// File: rtl/fmac_fifo_rd_framer.sv
// Drains length-prefixed frames (2-byte big-endian length + payload) from the MAC byte FIFO.
// Latency: first payload byte valid 4 cycles after the first read; 1 byte/cycle sustained.
// Backpressure: reads are credited against a 2-entry output buffer, so tx_ready low stalls reads.
module fmac_fifo_rd_framer #(
    parameter int WIDTH   = 8,
    parameter int PTR     = 12,
    parameter int MAX_LEN = 1518,
    parameter int LEN_W   = 16
) (
    input  logic             clk,
    input  logic             reset_,
    output logic             fifo_rdreq,
    input  logic [WIDTH-1:0] fifo_q,
    input  logic             fifo_rdempty,
    input  logic [PTR:0]     fifo_rdusedw,
    output logic [WIDTH-1:0] tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             tx_sop,
    output logic             tx_eop,
    output logic             len_err,
    output logic [15:0]      frm_cnt,
    output logic             busy
);
    typedef enum logic [1:0] {HDR_HI, HDR_LO, PAYLOAD, DROP} state_t;
    typedef struct packed {
        logic             sop;
        logic             eop;
        logic [WIDTH-1:0] dat;
    } beat_t;

    state_t           state_q;
    logic             inflight_q;
    logic             sop_pend_q;
    logic             len_err_q;
    logic [WIDTH-1:0] len_hi_q;
    logic [LEN_W-1:0] rem_q;
    logic [1:0]       occ_q;
    beat_t            buf0_q;
    beat_t            buf1_q;
    logic [15:0]      frm_cnt_q;

    logic [LEN_W-1:0] hdr_len;
    logic [1:0]       used;
    logic             push;
    logic             pop;
    beat_t            push_beat;
    logic             unused_rdusedw;

    assign hdr_len        = {len_hi_q, fifo_q};
    assign used           = occ_q + {1'b0, inflight_q};
    assign pop            = tx_valid && tx_ready;
    assign push           = inflight_q && (state_q == PAYLOAD);
    assign push_beat      = {sop_pend_q, (rem_q == LEN_W'(1)), fifo_q};
    assign unused_rdusedw = ^fifo_rdusedw;

    // Every outstanding read owns a buffer slot, header and dropped bytes included.
    assign fifo_rdreq = reset_ && !fifo_rdempty &&
                        ((used < 2'd2) || ((used == 2'd2) && pop));

    assign tx_valid = (occ_q != 2'd0);
    assign tx_data  = buf0_q.dat;
    assign tx_sop   = tx_valid && buf0_q.sop;
    assign tx_eop   = tx_valid && buf0_q.eop;
    assign len_err  = len_err_q;
    assign frm_cnt  = frm_cnt_q;
    assign busy     = (state_q != HDR_HI) || (occ_q != 2'd0);

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q    <= HDR_HI;
            inflight_q <= 1'b0;
            sop_pend_q <= 1'b0;
            len_err_q  <= 1'b0;
            len_hi_q   <= '0;
            rem_q      <= '0;
            occ_q      <= 2'd0;
            buf0_q     <= '0;
            buf1_q     <= '0;
            frm_cnt_q  <= '0;
        end else begin
            inflight_q <= fifo_rdreq;
            len_err_q  <= 1'b0;

            if (inflight_q) begin
                case (state_q)
                    HDR_HI: begin
                        len_hi_q <= fifo_q;
                        state_q  <= HDR_LO;
                    end
                    HDR_LO: begin
                        if (hdr_len == '0) begin
                            len_err_q <= 1'b1;
                            state_q   <= HDR_HI;
                        end else if (hdr_len > LEN_W'(MAX_LEN)) begin
                            len_err_q <= 1'b1;
                            rem_q     <= hdr_len;
                            state_q   <= DROP;
                        end else begin
                            rem_q      <= hdr_len;
                            sop_pend_q <= 1'b1;
                            state_q    <= PAYLOAD;
                        end
                    end
                    PAYLOAD: begin
                        sop_pend_q <= 1'b0;
                        rem_q      <= rem_q - LEN_W'(1);
                        if (rem_q == LEN_W'(1)) state_q <= HDR_HI;
                    end
                    DROP: begin
                        rem_q <= rem_q - LEN_W'(1);
                        if (rem_q == LEN_W'(1)) state_q <= HDR_HI;
                    end
                    default: state_q <= HDR_HI;
                endcase
            end

            // buf0 is always the head; buf1 only holds data when occ is 2.
            case ({push, pop})
                2'b10: begin
                    if (occ_q == 2'd0) buf0_q <= push_beat;
                    else               buf1_q <= push_beat;
                    occ_q <= occ_q + 2'd1;
                end
                2'b01: begin
                    buf0_q <= buf1_q;
                    occ_q  <= occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        buf0_q <= push_beat;
                    end else begin
                        buf0_q <= buf1_q;
                        buf1_q <= push_beat;
                    end
                end
                default: ;
            endcase

            if (pop && tx_eop) frm_cnt_q <= frm_cnt_q + 16'd1;
        end
    end
endmodule

// File: tb/tb_fmac_fifo_rd_framer.sv
// Bench for fmac_fifo_rd_framer: FIFO model, frame-level expected stream, cycle vectors for the first frame.
`timescale 1ns/1ps
module tb_fmac_fifo_rd_framer;
    localparam int MAX_LEN = 1518;

    logic        clk = 1'b0;
    logic        reset_;
    logic        fifo_rdreq;
    logic [7:0]  fifo_q;
    logic        fifo_rdempty;
    logic [12:0] fifo_rdusedw;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_sop;
    logic        tx_eop;
    logic        len_err;
    logic [15:0] frm_cnt;
    logic        busy;

    fmac_fifo_rd_framer #(.WIDTH(8), .PTR(12), .MAX_LEN(MAX_LEN), .LEN_W(16)) dut (
        .clk(clk), .reset_(reset_),
        .fifo_rdreq(fifo_rdreq), .fifo_q(fifo_q), .fifo_rdempty(fifo_rdempty), .fifo_rdusedw(fifo_rdusedw),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_sop(tx_sop), .tx_eop(tx_eop),
        .len_err(len_err), .frm_cnt(frm_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic sop; logic eop; logic [7:0] data; } beat_t;
    typedef struct {
        logic        ready;
        logic        rdreq;
        logic        valid;
        logic [7:0]  data;
        logic        sop;
        logic        eop;
        logic        busy;
        logic [15:0] frm;
    } vec_t;

    logic [7:0] src[$];
    logic [7:0] mq[$];
    beat_t      exp_q[$];
    int         beat_cyc[$];
    int         exp_err = 0, seen_err = 0, exp_frames = 0;
    int         n_chk = 0, n_pass = 0, cyc = 0;
    int         rdy_mode = 0;
    bit         trickle = 0;
    bit         rd_s, prev_stall = 0;
    beat_t      prev_beat;
    logic       s_rdreq, s_valid, s_sop, s_eop, s_busy, s_len_err;
    logic [7:0] s_data;
    logic [15:0] s_frm;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    function automatic void add_frame(input int len, input logic [7:0] base, input logic [7:0] stp);
        logic [15:0] l;
        logic [7:0]  d;
        beat_t       b;
        l = 16'(len);
        src.push_back(l[15:8]);
        src.push_back(l[7:0]);
        d = base;
        for (int i = 0; i < len; i++) begin
            src.push_back(d);
            if (len <= MAX_LEN) begin
                b = {(i == 0), (i == len - 1), d};
                exp_q.push_back(b);
            end
            d = d + stp;
        end
        if (len == 0 || len > MAX_LEN) exp_err++;
        else exp_frames++;
    endfunction

    task automatic observe();
        beat_t b;
        s_rdreq = fifo_rdreq; s_valid = tx_valid; s_data = tx_data; s_sop = tx_sop;
        s_eop = tx_eop; s_busy = busy; s_frm = frm_cnt; s_len_err = len_err;
        rd_s = fifo_rdreq;
        if (!reset_) begin
            prev_stall = 0;
        end else begin
            if (fifo_rdempty) chk(!fifo_rdreq, "rdreq_while_empty", 32'(fifo_rdreq), 32'd0);
            if (prev_stall)
                chk(tx_valid && ({tx_sop, tx_eop, tx_data} == prev_beat), "stall_hold",
                    32'({tx_valid, tx_sop, tx_eop, tx_data}), 32'({1'b1, prev_beat}));
            if (tx_valid && tx_ready) begin
                beat_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk(0, "extra_beat", 32'({tx_sop, tx_eop, tx_data}), 32'd0);
                end else begin
                    b = exp_q.pop_front();
                    chk({tx_sop, tx_eop, tx_data} == b, "beat", 32'({tx_sop, tx_eop, tx_data}), 32'(b));
                end
            end
            if (len_err) seen_err++;
            prev_stall = tx_valid && !tx_ready;
            prev_beat  = {tx_sop, tx_eop, tx_data};
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step();
        if (trickle) begin
            if (src.size() > 0 && $urandom_range(0, 1) == 1) mq.push_back(src.pop_front());
        end else begin
            while (src.size() > 0) mq.push_back(src.pop_front());
        end
        case (rdy_mode)
            0: tx_ready = 1'b1;
            1: tx_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            2: tx_ready = 1'($urandom_range(0, 1));
            3: tx_ready = 1'b0;
            default: ;
        endcase
        fifo_rdempty = (mq.size() == 0);
        fifo_rdusedw = 13'(mq.size());
        #1;
        observe();
        @(posedge clk);
        #1;
        if (rd_s && mq.size() > 0) fifo_q = mq.pop_front();
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain(input string name);
        int b = 0;
        while ((src.size() > 0 || mq.size() > 0 || exp_q.size() > 0 || busy) && b < 20000) begin
            step();
            b++;
        end
        step();
        step();
        chk(b < 20000, {name, "_timeout"}, 32'(b), 32'd20000);
        chk(exp_q.size() == 0, {name, "_missing_beats"}, 32'(exp_q.size()), 32'd0);
        chk(seen_err == exp_err, {name, "_len_err"}, 32'(seen_err), 32'(exp_err));
        chk(frm_cnt == 16'(exp_frames), {name, "_frm_cnt"}, 32'(frm_cnt), 32'(exp_frames));
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16'd0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16'd0};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 8'hA1, 1'b1, 1'b0, 1'b1, 16'd0};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 16'd0};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 8'hA3, 1'b0, 1'b1, 1'b1, 16'd0};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd1};

        reset_ = 1'b0; tx_ready = 1'b1; fifo_q = 8'h00; fifo_rdempty = 1'b1; fifo_rdusedw = '0;
        @(negedge clk);
        src.push_back(8'h00);
        step();
        step();
        chk({s_rdreq, s_valid, s_data, s_sop, s_eop, s_len_err, s_frm, s_busy} == '0, "reset_outputs",
            32'({s_rdreq, s_valid, s_data, s_sop, s_eop, s_len_err, s_busy}), 32'd0);
        mq.delete();
        src.delete();
        reset_ = 1'b1;
        step();
        step();

        // Single 3-byte frame, cycle by cycle.
        add_frame(3, 8'hA1, 8'h01);
        rdy_mode = 4;
        for (int i = 0; i < 8; i++) begin
            tx_ready = vecs[i].ready;
            step();
            chk({s_rdreq, s_valid, s_data & {8{s_valid}}, s_sop, s_eop, s_busy, s_frm} ==
                {vecs[i].rdreq, vecs[i].valid, vecs[i].data, vecs[i].sop, vecs[i].eop, vecs[i].busy, vecs[i].frm},
                $sformatf("vec%0d", i),
                32'({s_rdreq, s_valid, s_data & {8{s_valid}}, s_sop, s_eop, s_busy, s_frm}),
                32'({vecs[i].rdreq, vecs[i].valid, vecs[i].data, vecs[i].sop, vecs[i].eop, vecs[i].busy, vecs[i].frm}));
        end
        rdy_mode = 0;
        drain("single");

        // Back-to-back frames: 2-cycle header gap between 22 and 33.
        beat_cyc.delete();
        add_frame(2, 8'h11, 8'h11);
        add_frame(1, 8'h33, 8'h00);
        drain("b2b");
        chk(beat_cyc.size() == 3, "b2b_beats", 32'(beat_cyc.size()), 32'd3);
        if (beat_cyc.size() == 3) begin
            chk(beat_cyc[1] - beat_cyc[0] == 1, "b2b_inner", 32'(beat_cyc[1] - beat_cyc[0]), 32'd1);
            chk(beat_cyc[2] - beat_cyc[1] == 3, "b2b_gap", 32'(beat_cyc[2] - beat_cyc[1]), 32'd3);
        end

        rdy_mode = 1;
        add_frame(6, 8'h60, 8'h01);
        drain("backpressure");

        rdy_mode = 0;
        add_frame(0, 8'h00, 8'h00);
        add_frame(1, 8'h55, 8'h00);
        drain("zero_len");

        add_frame(1536, 8'h00, 8'h01);
        add_frame(1, 8'h77, 8'h00);
        drain("drop_1536");

        add_frame(MAX_LEN, 8'h10, 8'h03);
        add_frame(MAX_LEN + 1, 8'h20, 8'h01);
        add_frame(1, 8'h88, 8'h00);
        drain("len_boundary");

        for (int batch = 0; batch < 4; batch++) begin
            rdy_mode = (batch == 0) ? 0 : ((batch == 1) ? 1 : 2);
            trickle  = (batch >= 2);
            for (int f = 0; f < 15; f++) begin
                int r;
                r = int'($urandom_range(0, 9));
                add_frame((r == 0) ? 0 : int'($urandom_range(1, 12)), 8'($urandom), 8'($urandom));
            end
            drain($sformatf("random%0d", batch));
        end
        trickle = 0;

        // Reset mid-frame: header says 4, only 2 payload bytes present, output stalled.
        src.push_back(8'h00); src.push_back(8'h04); src.push_back(8'hB1); src.push_back(8'hB2);
        rdy_mode = 3;
        for (int i = 0; i < 6; i++) step();
        chk(tx_valid && tx_data == 8'hB1, "pre_reset_head", 32'({tx_valid, tx_data}), 32'h1B1);
        reset_ = 1'b0;
        mq.delete();
        src.delete();
        exp_q.delete();
        #1;
        chk({tx_valid, busy, frm_cnt} == '0, "mid_reset_clear", 32'({tx_valid, busy, frm_cnt}), 32'd0);
        step();
        step();
        reset_ = 1'b1;
        exp_frames = 0;
        rdy_mode = 0;
        add_frame(1, 8'hC3, 8'h00);
        drain("after_reset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fmac_fifo_rd_framer.md
Name: fmac_fifo_rd_framer

Overview:
- Read-side drainer for the MAC's 4Kx8 byte FIFO (rdreq/q/rdempty/rdusedw side).
- The FIFO holds length-prefixed frames: a 2-byte big-endian length, then that many payload bytes.
- This block pops the FIFO, strips and checks the header, and presents the payload as a byte stream with valid/ready and sop/eop flags to the MAC transmit path.
- It is the consumer counterpart to the FIFO write side fed by the MAC ingress logic.

Parameters:
- WIDTH, 8, FIFO/stream data width.
- PTR, 12, FIFO pointer width; the used-word count is PTR+1 bits.
- MAX_LEN, 1518, largest legal payload length in bytes.
- LEN_W, 16, header length field width.

Ports:
- clk  in  1  single clock, shared by FIFO read side and stream.
- reset_  in  1  asynchronous, active-low reset.
- fifo_rdreq  out  1  FIFO read request; one byte per asserted cycle.
- fifo_q  in  WIDTH  FIFO read data; valid the cycle after fifo_rdreq.
- fifo_rdempty  in  1  FIFO empty.
- fifo_rdusedw  in  PTR+1  FIFO occupancy; status only, not used for flow control.
- tx_data  out  WIDTH  payload byte.
- tx_valid  out  1  tx_data/tx_sop/tx_eop valid.
- tx_ready  in  1  downstream accepts the byte when tx_valid&&tx_ready.
- tx_sop  out  1  first payload byte of a frame.
- tx_eop  out  1  last payload byte of a frame.
- len_err  out  1  one-cycle pulse when a header carries length 0 or a length above MAX_LEN.
- frm_cnt  out  16  count of frames whose eop byte was accepted; wraps at 0xFFFF.
- busy  out  1  high while a frame is mid-parse (state other than HDR_HI) or the buffer is non-empty.

Behaviour:
- Reset: one clock and one reset only (clk; reset_ asynchronous, active-low). While reset_=0:
  - fifo_rdreq=0, tx_valid=0, tx_data=0, tx_sop=0, tx_eop=0, len_err=0, frm_cnt=0, busy=0.
  - State=HDR_HI, in-flight flag=0, buffer emptied.
  - Asserting reset mid-frame discards the partial frame and all buffered bytes. The FIFO is expected to be cleared by the same reset.
- Request side:
  - fifo_rdreq = !fifo_rdempty && (occ + inflight < 2 || (occ + inflight == 2 && tx_valid && tx_ready)).
  - occ = buffer entries (0..2). inflight = 1 if fifo_rdreq was high last cycle.
  - Header and dropped bytes also consume credit.
  - fifo_rdreq is never asserted while fifo_rdempty=1.
- Return side: fifo_q is sampled when inflight=1 and classified by the return state machine.
  - HDR_HI: capture len[15:8], go to HDR_LO.
  - HDR_LO: form len = {hi, q}.
    - len==0: pulse len_err, go to HDR_HI.
    - len>MAX_LEN: pulse len_err, load remaining count=len, go to DROP.
    - Otherwise: load remaining count=len, set sop_pending, go to PAYLOAD.
  - PAYLOAD: push {q, sop_pending, remaining==1} into the buffer, clear sop_pending, decrement remaining. At remaining==1, go to HDR_HI.
  - DROP: discard the byte, decrement remaining. At remaining==1, go to HDR_HI. No stream output.
- Buffer:
  - 2-entry FIFO; the head drives tx_data/tx_sop/tx_eop/tx_valid.
  - A pushed byte appears on tx_valid no earlier than the cycle after it is on fifo_q.
  - Simultaneous push and pop is allowed. The buffer can never overflow, by the credit rule above.
  - Outputs hold stable while tx_valid && !tx_ready.
- Latency and throughput:
  - With the FIFO non-empty at cycle 0 and tx_ready=1: rdreq in cycles 0,1,2,...; first payload byte has tx_valid in cycle 4.
  - Steady state is 1 byte per cycle, including back-to-back frames (2-cycle header gap per frame).
- Length 1 frame: a single byte with tx_sop=tx_eop=1.
- frm_cnt increments on tx_valid && tx_ready && tx_eop.
- FIFO going empty mid-frame: reads pause and state is held; parsing resumes on the next byte with no data loss.

Test Plan:
- Reset, then load FIFO with 00 03 A1 A2 A3; tx_ready=1.
  - -> rdreq cycles 0-4; tx_valid cycles 4-6 with A1(sop), A2, A3(eop); frm_cnt=1; len_err never asserted.
- Back-to-back frames 00 02 11 22 00 01 33, tx_ready=1.
  - -> stream 11(sop), 22(eop), then 33(sop+eop) after a 2-cycle gap; frm_cnt=2.
- Backpressure: frame length 6; tx_ready toggled 1,0,0,1,...
  - -> tx_data stable while stalled; all 6 bytes in order; occ never exceeds 2; fifo_rdreq low while credits are exhausted.
- Header 00 00, then 00 01 55.
  - -> len_err pulses once after the second header byte returns; only 55(sop+eop) is output; frm_cnt=1.
- Header 06 00 (1536 > MAX_LEN) + 1536 bytes, then 00 01 77.
  - -> len_err pulse; no tx_valid during the dropped bytes; then 77 output; frm_cnt=1.
- Frame 00 04 with only 2 payload bytes written, then reset_ pulsed low mid-frame.
  - -> tx_valid drops immediately; state=HDR_HI, frm_cnt=0; a fresh frame afterwards parses correctly.
